// File: rtl/rx_psdu_deframer_pkg.sv
// -----------------------------------------------------------------------------
// rx_psdu_deframer_pkg
// Shared definitions for the PSDU deframer (and the transmit-side framer):
//   - RATE code constants and the RATE -> N_DBPS lookup
//   - RXVECTOR field offsets
//   - deframer state enum
// No ports (package).
// -----------------------------------------------------------------------------
package rx_psdu_deframer_pkg;

    localparam logic [3:0] RATE_6M  = 4'b1011;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b1010;
    localparam logic [3:0] RATE_18M = 4'b1110;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1101;
    localparam logic [3:0] RATE_48M = 4'b1000;
    localparam logic [3:0] RATE_54M = 4'b1100;

    localparam int RXV_W           = 35;
    localparam int RXV_SERVICE_LSB = 0;
    localparam int RXV_RATE_LSB    = 16;
    localparam int RXV_RSSI_LSB    = 20;
    localparam int RXV_LENGTH_LSB  = 23;

    localparam int SERVICE_BITS = 16;
    localparam int TAIL_BITS    = 6;

    typedef enum logic [1:0] {
        IDLE,
        SERVICE,
        PSDU,
        TAILPAD
    } deframer_state_t;

    // Data bits per OFDM symbol for a RATE code; 0 flags an illegal code.
    function automatic logic [7:0] n_dbps_of(input logic [3:0] rate);
        logic [7:0] n;
        n = 8'd0;
        case (rate)
            RATE_6M:  n = 8'd24;
            RATE_9M:  n = 8'd36;
            RATE_12M: n = 8'd48;
            RATE_18M: n = 8'd72;
            RATE_24M: n = 8'd96;
            RATE_36M: n = 8'd144;
            RATE_48M: n = 8'd192;
            RATE_54M: n = 8'd216;
            default:  n = 8'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rx_psdu_deframer_if.sv
// -----------------------------------------------------------------------------
// rx_psdu_deframer_if
// Byte stream from the deframer to the MAC (valid/ready).
//   out_data  : PSDU byte at FIFO head
//   out_valid : a byte is available
//   out_last  : out_data is the final PSDU byte of its frame
//   out_ready : MAC accepts the head byte when out_valid && out_ready
// master = deframer side, slave = MAC side.
// -----------------------------------------------------------------------------
interface rx_psdu_deframer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/rx_psdu_deframer_fifo.sv
// -----------------------------------------------------------------------------
// rx_byte_fifo
// Synchronous FIFO holding PSDU bytes plus their last-byte flag.
//   clock, reset   : rising-edge clock, synchronous active-low reset
//   push/push_data : write request and word {last, byte}
//   pop            : read request (head word advances)
//   pop_data       : head word (only meaningful while !empty)
//   full, empty    : occupancy flags
// A pop and a push in the same cycle are both honoured even when full.
// -----------------------------------------------------------------------------
module rx_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rx_psdu_deframer.sv
// -----------------------------------------------------------------------------
// rx_psdu_deframer
// Strips SERVICE bits from the descrambled receive bit stream, assembles PSDU
// bytes LSB-first, queues them for the MAC and discards tail/pad bits.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   start        : pulse that latches rxvector and arms a frame (IDLE only)
//   rxvector     : {LENGTH, RSSI, RATE, SERVICE}
//   bit_in/bit_valid : descrambled bit stream, no backpressure
//   out_if       : byte stream to the MAC (master side)
//   frame_done   : pulse after the last pad bit
//   rate_err, service_err, overflow : sticky error flags
//   busy         : frame in progress
// rxvector's LENGTH field is 12 bits wide, matching the default LEN_W.
// -----------------------------------------------------------------------------
module rx_psdu_deframer
    import rx_psdu_deframer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [RXV_W-1:0] rxvector,
    input  logic             bit_in,
    input  logic             bit_valid,
    rx_psdu_deframer_if.master out_if,
    output logic             frame_done,
    output logic             rate_err,
    output logic             service_err,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = LEN_W + 4;

    deframer_state_t state, state_d;
    logic [LEN_W-1:0] length_q;
    logic [7:0]       n_dbps_q;
    logic [CW-1:0]    bit_cnt;
    logic [7:0]       sym_cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic [7:0]       shreg;
    logic             frame_done_q;
    logic             rate_err_q;
    logic             service_err_q;
    logic             overflow_q;

    logic [3:0]       rate_in;
    logic [7:0]       n_dbps_in;
    logic             rate_legal;
    logic [LEN_W-1:0] len_in;
    logic             bit_take;
    logic [CW-1:0]    bit_cnt_inc;
    logic             sym_wrap;
    logic [CW-1:0]    tail_thresh;
    logic [7:0]       byte_val;
    logic             byte_done;
    logic             byte_last;
    logic             tail_exit;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [8:0]       fifo_head;
    logic             unused_rxv;

    assign rate_in    = rxvector[RXV_RATE_LSB +: 4];
    assign n_dbps_in  = n_dbps_of(rate_in);
    assign rate_legal = (n_dbps_in != 8'd0);
    assign len_in     = rxvector[RXV_LENGTH_LSB +: LEN_W];
    assign unused_rxv = ^{rxvector[RXV_RSSI_LSB +: 3], rxvector[RXV_SERVICE_LSB +: 16]};

    assign bit_take    = bit_valid && (state != IDLE);
    assign bit_cnt_inc = bit_cnt + CW'(1);
    assign sym_wrap    = (sym_cnt == n_dbps_q - 8'd1);
    // Bits that must be seen before the pad may end: SERVICE + PSDU + tail.
    assign tail_thresh = CW'({length_q, 3'b000}) + CW'(SERVICE_BITS + TAIL_BITS);

    // After SERVICE the low three bits of bit_cnt give the bit position
    // within the current PSDU byte.
    assign byte_val  = {bit_in, shreg[7:1]};
    assign byte_done = (state == PSDU) && bit_valid && (bit_cnt[2:0] == 3'd7);
    assign byte_last = (byte_cnt == length_q - LEN_W'(1));
    assign tail_exit = (state == TAILPAD) && bit_valid && sym_wrap &&
                       (bit_cnt_inc >= tail_thresh);

    assign fifo_pop = out_if.out_ready && !fifo_empty;

    // Next-state logic for the frame walk.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start && rate_legal) state_d = SERVICE;
            end
            SERVICE: begin
                if (bit_valid && bit_cnt == CW'(SERVICE_BITS - 1))
                    state_d = (length_q != '0) ? PSDU : TAILPAD;
            end
            PSDU: begin
                if (byte_done && byte_last) state_d = TAILPAD;
            end
            TAILPAD: begin
                if (tail_exit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, counters, byte assembly and sticky flags. Frame setup
    // and rate_err only happen in IDLE, where no bit is counted, so those
    // updates never collide with the per-bit updates.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            length_q      <= '0;
            n_dbps_q      <= '0;
            bit_cnt       <= '0;
            sym_cnt       <= '0;
            byte_cnt      <= '0;
            shreg         <= '0;
            frame_done_q  <= 1'b0;
            rate_err_q    <= 1'b0;
            service_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state        <= state_d;
            frame_done_q <= tail_exit;

            if (state == IDLE && start) begin
                if (rate_legal) begin
                    length_q      <= len_in;
                    n_dbps_q      <= n_dbps_in;
                    bit_cnt       <= '0;
                    sym_cnt       <= '0;
                    byte_cnt      <= '0;
                    rate_err_q    <= 1'b0;
                    service_err_q <= 1'b0;
                    overflow_q    <= 1'b0;
                end else begin
                    rate_err_q <= 1'b1;
                end
            end

            if (bit_take) begin
                bit_cnt <= bit_cnt_inc;
                sym_cnt <= sym_wrap ? 8'd0 : sym_cnt + 8'd1;
            end

            if (state == SERVICE && bit_valid && bit_in) service_err_q <= 1'b1;
            if (state == PSDU && bit_valid)               shreg <= byte_val;
            if (byte_done)                                byte_cnt <= byte_cnt + LEN_W'(1);
            if (byte_done && fifo_full && !fifo_pop)      overflow_q <= 1'b1;
        end
    end

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (byte_done),
        .push_data ({byte_last, byte_val}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head word is forced to zero while empty so the outputs read 0 out of
    // reset rather than stale storage.
    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = fifo_empty ? 8'd0 : fifo_head[7:0];
    assign out_if.out_last  = fifo_empty ? 1'b0 : fifo_head[8];

    assign frame_done  = frame_done_q;
    assign rate_err    = rate_err_q;
    assign service_err = service_err_q;
    assign overflow    = overflow_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_rx_psdu_deframer.sv
// -----------------------------------------------------------------------------
// tb_rx_psdu_deframer
// Self-checking bench for rx_psdu_deframer. Frames are built from a RATE,
// LENGTH, SERVICE word and a byte list; expected bytes and frame lengths
// come from the frame format arithmetic, compared with what the MAC side
// collects.
// -----------------------------------------------------------------------------
module tb_rx_psdu_deframer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [34:0] rxvector;
    logic        bit_in;
    logic        bit_valid;
    logic        frame_done;
    logic        rate_err;
    logic        service_err;
    logic        overflow;
    logic        busy;

    rx_psdu_deframer_if dut_if ();

    rx_psdu_deframer #(
        .FIFO_DEPTH (4),
        .LEN_W      (12)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .rxvector    (rxvector),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .out_if      (dut_if),
        .frame_done  (frame_done),
        .rate_err    (rate_err),
        .service_err (service_err),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    logic [7:0] tx_bytes [$];
    logic [8:0] got_q    [$];
    bit         rand_ready = 1'b0;
    bit         use_gaps   = 1'b0;
    int         low_streak = 0;
    int         stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_head  = '0;

    logic [3:0] rate_tab [8] = '{4'b1011, 4'b1111, 4'b1010, 4'b1110,
                                 4'b1001, 4'b1101, 4'b1000, 4'b1100};
    int         dbps_tab [8] = '{24, 36, 48, 72, 96, 144, 192, 216};

    // MAC-side collector plus a check that a stalled head word holds steady.
    always @(negedge clock) begin
        if (reset) begin
            if (prev_stall && ({dut_if.out_valid, dut_if.out_last, dut_if.out_data} !== {1'b1, prev_head}))
                stall_viol++;
            if (dut_if.out_valid && dut_if.out_ready)
                got_q.push_back({dut_if.out_last, dut_if.out_data});
            prev_stall = dut_if.out_valid && !dut_if.out_ready;
            prev_head  = {dut_if.out_last, dut_if.out_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic int ref_dbps(input logic [3:0] rate);
        for (int k = 0; k < 8; k++)
            if (rate_tab[k] == rate) return dbps_tab[k];
        return 0;
    endfunction

    // Whole symbols needed to carry SERVICE + PSDU + tail.
    function automatic int ref_frame_bits(input int len, input int n);
        return ((22 + 8 * len + n - 1) / n) * n;
    endfunction

    // One clock step; time always sits 1 unit after a rising edge.
    task automatic step();
        if (rand_ready) begin
            if (low_streak >= 4) dut_if.out_ready = 1'b1;
            else dut_if.out_ready = 1'($urandom_range(0, 1));
            low_streak = dut_if.out_ready ? 0 : low_streak + 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] rate, input int len, input logic [15:0] svc,
                              input int stop_bit, output int done_at, output int done_cnt,
                              output int ovf_at);
        int         nbits;
        int         n;
        logic [7:0] cur;
        n        = ref_dbps(rate);
        nbits    = ref_frame_bits(len, n);
        done_at  = 0;
        done_cnt = 0;
        ovf_at   = 0;
        rxvector  = {12'(len), 3'b101, rate, 16'h0000};
        start     = 1'b1;
        bit_valid = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (stop_bit != 0 && i == stop_bit) break;
            if (use_gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    bit_valid = 1'b0;
                    start     = ($urandom_range(0, 5) == 0);
                    rxvector  = 35'd0;
                    step();
                    if (frame_done) done_cnt++;
                end
            end
            start     = 1'b0;
            bit_valid = 1'b1;
            if (i < 16) begin
                bit_in = svc[i];
            end else if (i < 16 + 8 * len) begin
                cur    = tx_bytes[(i - 16) / 8];
                bit_in = cur[(i - 16) % 8];
            end else begin
                bit_in = 1'($urandom_range(0, 1));
            end
            step();
            if (frame_done) begin
                done_cnt++;
                if (done_at == 0) done_at = i + 1;
            end
            if (overflow && ovf_at == 0) ovf_at = i + 1;
        end
        bit_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic drain(input int expect_n);
        for (int c = 0; c < 400 && got_q.size() < expect_n; c++) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        rxvector = '0;
        dut_if.out_ready = 1'b0;
        step();
        step();
        checks++; if (dut_if.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", dut_if.out_valid); else passed++;
        checks++; if (dut_if.out_data !== 8'h00) $display("[TB] FAIL reset_out_data got %h want 00", dut_if.out_data); else passed++;
        checks++; if (dut_if.out_last !== 1'b0) $display("[TB] FAIL reset_out_last got %b want 0", dut_if.out_last); else passed++;
        checks++; if ({frame_done, rate_err, service_err, overflow, busy} !== 5'b0)
            $display("[TB] FAIL reset_flags got %b want 00000", {frame_done, rate_err, service_err, overflow, busy}); else passed++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_byte();
        int d, dc, o;
        tx_bytes = '{8'hA5};
        got_q.delete();
        dut_if.out_ready = 1'b1;
        send_frame(4'b1011, 1, 16'h0000, 0, d, dc, o);
        checks++; if (d !== 48) $display("[TB] FAIL single_done_bit got %0d want 48", d); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL single_busy got %b want 0", busy); else passed++;
        drain(1);
        checks++; if (got_q.size() !== 1) $display("[TB] FAIL single_count got %0d want 1", got_q.size()); else passed++;
        if (got_q.size() > 0) begin
            checks++; if (got_q[0] !== 9'h1A5) $display("[TB] FAIL single_byte got %h want 1a5", got_q[0]); else passed++;
        end
        checks++; if ({service_err, overflow, rate_err} !== 3'b000)
            $display("[TB] FAIL single_flags got %b want 000", {service_err, overflow, rate_err}); else passed++;
    endtask

    task automatic test_long_frame();
        int d, dc, o;
        tx_bytes.delete();
        for (int k = 0; k < 100; k++) tx_bytes.push_back(8'(k));
        got_q.delete();
        dut_if.out_ready = 1'b1;
        send_frame(4'b1100, 100, 16'h0000, 0, d, dc, o);
        checks++; if (d !== 864) $display("[TB] FAIL long_done_bit got %0d want 864", d); else passed++;
        drain(100);
        checks++; if (got_q.size() !== 100) $display("[TB] FAIL long_count got %0d want 100", got_q.size()); else passed++;
        for (int k = 0; k < 100 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== {(k == 99), 8'(k)})
                $display("[TB] FAIL long_byte%0d got %h want %h", k, got_q[k], {(k == 99), 8'(k)});
            else passed++;
        end
    endtask

    task automatic test_overflow();
        int d, dc, o;
        tx_bytes.delete();
        for (int k = 0; k < 6; k++) tx_bytes.push_back(8'($urandom_range(0, 255)));
        got_q.delete();
        dut_if.out_ready = 1'b0;
        send_frame(4'b1011, 6, 16'h0000, 0, d, dc, o);
        checks++; if (o !== 56) $display("[TB] FAIL ovf_bit got %0d want 56", o); else passed++;
        checks++; if (d !== 72) $display("[TB] FAIL ovf_done_bit got %0d want 72", d); else passed++;
        checks++; if (got_q.size() !== 0) $display("[TB] FAIL ovf_held got %0d want 0", got_q.size()); else passed++;
        dut_if.out_ready = 1'b1;
        drain(4);
        step(); step(); step();
        checks++; if (got_q.size() !== 4) $display("[TB] FAIL ovf_drain_count got %0d want 4", got_q.size()); else passed++;
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== {1'b0, tx_bytes[k]})
                $display("[TB] FAIL ovf_byte%0d got %h want %h", k, got_q[k], {1'b0, tx_bytes[k]});
            else passed++;
        end
        checks++; if (dut_if.out_valid !== 1'b0) $display("[TB] FAIL ovf_empty got %b want 0", dut_if.out_valid); else passed++;
    endtask

    task automatic test_rate_err();
        int d, dc, o;
        rxvector = {12'd5, 3'b000, 4'b0000, 16'h0000};
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (rate_err !== 1'b1) $display("[TB] FAIL rate_err_set got %b want 1", rate_err); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rate_err_busy got %b want 0", busy); else passed++;
        for (int k = 0; k < 40; k++) begin
            bit_valid = 1'b1;
            bit_in = 1'($urandom_range(0, 1));
            step();
        end
        bit_valid = 1'b0;
        checks++; if ({busy, dut_if.out_valid, rate_err} !== 3'b001)
            $display("[TB] FAIL rate_err_ignore got %b want 001", {busy, dut_if.out_valid, rate_err}); else passed++;
        tx_bytes.delete();
        send_frame(4'b1011, 0, 16'h0000, 0, d, dc, o);
        checks++; if (rate_err !== 1'b0) $display("[TB] FAIL rate_err_clear got %b want 0", rate_err); else passed++;
        checks++; if (d !== 24) $display("[TB] FAIL len0_done_bit got %0d want 24", d); else passed++;
    endtask

    task automatic test_service_err();
        int d, dc, o;
        tx_bytes = '{8'h3C, 8'hC7};
        got_q.delete();
        dut_if.out_ready = 1'b1;
        send_frame(4'b1011, 2, 16'h0008, 0, d, dc, o);
        checks++; if (service_err !== 1'b1) $display("[TB] FAIL svc_err got %b want 1", service_err); else passed++;
        checks++; if (d !== 48 || dc !== 1) $display("[TB] FAIL svc_done got bit %0d pulses %0d want 48 1", d, dc); else passed++;
        drain(2);
        checks++; if (got_q.size() !== 2) $display("[TB] FAIL svc_count got %0d want 2", got_q.size()); else passed++;
        if (got_q.size() == 2) begin
            checks++; if ({got_q[0], got_q[1]} !== {9'h03C, 9'h1C7})
                $display("[TB] FAIL svc_bytes got %h %h want 03c 1c7", got_q[0], got_q[1]); else passed++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int d, dc, o;
        tx_bytes.delete();
        for (int k = 0; k < 10; k++) tx_bytes.push_back(8'($urandom_range(0, 255)));
        dut_if.out_ready = 1'b0;
        send_frame(4'b1011, 10, 16'h0001, 30, d, dc, o);
        reset = 1'b0;
        step();
        checks++;
        if ({dut_if.out_valid, dut_if.out_last, dut_if.out_data, frame_done, rate_err, service_err, overflow, busy} !== 15'd0)
            $display("[TB] FAIL midreset_outputs got %b want 0",
                     {dut_if.out_valid, dut_if.out_last, dut_if.out_data, frame_done, rate_err, service_err, overflow, busy});
        else passed++;
        reset = 1'b1;
        dut_if.out_ready = 1'b1;
        step();
        checks++; if (dut_if.out_valid !== 1'b0) $display("[TB] FAIL midreset_empty got %b want 0", dut_if.out_valid); else passed++;
        got_q.delete();
        tx_bytes = '{8'h81, 8'h42, 8'hF0};
        send_frame(4'b1111, 3, 16'h0000, 0, d, dc, o);
        checks++; if (d !== 72) $display("[TB] FAIL fresh_done_bit got %0d want 72", d); else passed++;
        drain(3);
        checks++;
        if (got_q.size() != 3 || {got_q[0], got_q[1], got_q[2]} !== {9'h081, 9'h042, 9'h1F0})
            $display("[TB] FAIL fresh_bytes got count %0d want 3 bytes 081 042 1f0", got_q.size());
        else passed++;
    endtask

    task automatic test_random_frames();
        int         d, dc, o, len, ri, nbits;
        logic [15:0] svc;
        use_gaps   = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            ri  = $urandom_range(0, 7);
            len = $urandom_range(0, 20);
            svc = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
            tx_bytes.delete();
            for (int k = 0; k < len; k++) tx_bytes.push_back(8'($urandom_range(0, 255)));
            got_q.delete();
            stall_viol = 0;
            nbits = ref_frame_bits(len, dbps_tab[ri]);
            send_frame(rate_tab[ri], len, svc, 0, d, dc, o);
            checks++; if (d !== nbits || dc !== 1)
                $display("[TB] FAIL rnd%0d_done got bit %0d pulses %0d want %0d 1", f, d, dc, nbits); else passed++;
            checks++; if ({rate_err, overflow, service_err} !== {2'b00, (svc != 16'h0)})
                $display("[TB] FAIL rnd%0d_flags got %b want %b", f, {rate_err, overflow, service_err}, {2'b00, (svc != 16'h0)}); else passed++;
            drain(len);
            step(); step();
            checks++; if (got_q.size() !== len)
                $display("[TB] FAIL rnd%0d_count got %0d want %0d", f, got_q.size(), len); else passed++;
            for (int k = 0; k < len && k < got_q.size(); k++) begin
                checks++;
                if (got_q[k] !== {(k == len - 1), tx_bytes[k]})
                    $display("[TB] FAIL rnd%0d_byte%0d got %h want %h", f, k, got_q[k], {(k == len - 1), tx_bytes[k]});
                else passed++;
            end
            checks++; if (stall_viol !== 0) $display("[TB] FAIL rnd%0d_stall got %0d want 0", f, stall_viol); else passed++;
        end
        use_gaps   = 1'b0;
        rand_ready = 1'b0;
    endtask

    initial begin
        $display("[TB] rx_psdu_deframer bench start");
        test_reset();
        test_single_byte();
        test_long_frame();
        test_overflow();
        test_rate_err();
        test_service_err();
        test_reset_mid_frame();
        test_random_frames();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rx_psdu_deframer.md
Name: rx_psdu_deframer

Overview:
- Receive-side stage directly downstream of the PHY receive chain; consumes the descrambled serial bit stream (RX_OUT / RX_OUT_VALID) and the RXVECTOR.
- Strips the 16 SERVICE bits, assembles PSDU bytes LSB-first and hands them to the MAC over a valid/ready interface through a small FIFO.
- Discards the 6 tail bits and the pad bits, and reports frame completion and errors.

Parameters:
- FIFO_DEPTH, 4, output byte FIFO entries; power of two, at least 2.
- LEN_W, 12, LENGTH field width in bytes.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; latches rxvector and arms a new frame.
- rxvector  in  35  {LENGTH[34:23], RSSI[22:20], RATE[19:16], SERVICE[15:0]}.
- bit_in  in  1  descrambled data bit.
- bit_valid  in  1  bit_in is valid this cycle; no backpressure toward the PHY.
- out_data  out  8  PSDU byte at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_last  out  1  out_data is the final PSDU byte of the frame.
- out_ready  in  1  MAC accepts the head byte when out_valid && out_ready.
- frame_done  out  1  one-cycle pulse when the last pad bit is consumed.
- rate_err  out  1  sticky; illegal RATE seen at start.
- service_err  out  1  sticky; descrambled SERVICE not all zero (non-fatal).
- overflow  out  1  sticky; a byte completed while the FIFO was full.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE, all counters 0, FIFO empty, every output 0. Reset mid-frame aborts the frame silently, with no frame_done. Sticky flags clear only on reset or on an accepted start.
- RATE to N_DBPS mapping:
  - 1011→24, 1111→36, 1010→48, 1110→72
  - 1001→96, 1101→144, 1000→192, 1100→216
  - any other value is illegal.
- IDLE:
  - start with a legal RATE: latch LENGTH and N_DBPS, clear sticky flags, bit_cnt=0, sym_cnt=0, go to SERVICE.
  - start with an illegal RATE: set rate_err and stay in IDLE.
  - bit_valid in IDLE is ignored.
- Counting: every valid bit in SERVICE, PSDU or TAILPAD increments bit_cnt (width LEN_W+4). sym_cnt wraps from N_DBPS-1 to 0.
- SERVICE:
  - Bits 0..15 are OR-reduced into service_err.
  - After the 16th bit: go to PSDU if LENGTH>0, else go to TAILPAD.
- PSDU:
  - Shift bits LSB-first into a byte register.
  - On the 8th bit, push the byte to the FIFO in the same cycle, tagged last if byte_cnt==LENGTH-1. out_valid rises on the next cycle.
  - After LENGTH bytes, go to TAILPAD.
  - Push while the FIFO is full: drop the byte, set overflow, keep counting.
- TAILPAD:
  - Discard bits.
  - Exit when bit_cnt >= 22+8*LENGTH and the current bit makes sym_cnt wrap to 0.
  - Total bits consumed = ceil((22+8L)/N_DBPS)*N_DBPS.
  - On exit: pulse frame_done and return to IDLE.
- start while busy: ignored. The frame in progress continues.
- FIFO:
  - Simultaneous push and pop when full is allowed; a pop frees a slot in the same cycle.
  - out_data and out_last are stable while out_valid && !out_ready.
  - The FIFO drains independently of state, so bytes may remain after frame_done.
- Arithmetic: 22+8*LENGTH is computed at LEN_W+4 bits with no overflow (max 32782).

Decomposition:
- Shared package: the RATE code constants and the N_DBPS lookup function (reused by the transmit side), the state enum {IDLE, SERVICE, PSDU, TAILPAD}, and the RXVECTOR field offsets.
- Sub-module: rx_byte_fifo, a synchronous 9-bit-wide FIFO of depth FIFO_DEPTH (8 data bits + last flag) with full/empty flags.

Test Plan:
- RATE=1011, LENGTH=1, SERVICE bits all 0, data byte 0xA5 sent LSB-first, out_ready=1 → one byte 0xA5 with out_last=1; frame_done after bit 48 (18 pad bits); busy low next cycle.
- RATE=1100, LENGTH=100, incrementing bytes 0x00..0x63 → 100 bytes in order, last flagged on 0x63; frame_done after bit 864 (4 symbols of 216).
- RATE=1011, LENGTH=6, out_ready=0 throughout → bytes 0–3 held in the FIFO, overflow=1 after the 5th byte completes. Then raise out_ready: 4 bytes drain, none tagged last.
- start with RATE=0000 → rate_err=1, busy stays 0, subsequent bits ignored. A following start with a legal RATE clears rate_err.
- SERVICE bit 3 =1, LENGTH=2 → service_err=1, both bytes still delivered, frame_done pulses.
- reset low at bit 30 of a LENGTH=10 frame → next cycle all outputs 0 and FIFO empty; a fresh frame afterwards decodes correctly.
